// File: rtl/llc_l1d_line_bridge.sv
// llc_l1d_line_bridge: turns LLC fill beats into whole L1D lines, and turns
// L1D writeback lines back into LLC beats. The two directions share only the
// clock and reset, so a fill and a writeback can be in flight together.
module llc_l1d_line_bridge #(
  parameter int PADDR_BITS = 19,
  parameter int B          = 64,
  parameter int W          = 64
) (
  input  logic                  clk_in,
  input  logic                  rst_N_in,
  input  logic                  flush_in,
  // fill beats from the LLC
  input  logic                  llc_valid_in,
  output logic                  llc_ready_out,
  input  logic [PADDR_BITS-1:0] llc_addr_in,
  input  logic [W-1:0]          llc_value_in,
  // assembled line to the L1D
  output logic                  l1d_valid_out,
  input  logic                  l1d_ready_in,
  output logic [PADDR_BITS-1:0] l1d_addr_out,
  output logic [8*B-1:0]        l1d_line_out,
  // writeback line from the L1D
  input  logic                  l1d_wb_valid_in,
  output logic                  l1d_wb_ready_out,
  input  logic [PADDR_BITS-1:0] l1d_wb_addr_in,
  input  logic [8*B-1:0]        l1d_wb_line_in,
  // writeback beats to the LLC
  output logic                  llc_wb_valid_out,
  input  logic                  llc_wb_ready_in,
  output logic [PADDR_BITS-1:0] llc_wb_addr_out,
  output logic [W-1:0]          llc_wb_value_out,
  output logic                  protocol_err_out
);

  localparam int BEATS = (8 * B) / W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0]         LAST_BEAT = CW'(BEATS - 1);
  localparam logic [PADDR_BITS-1:0] LINE_MASK = ~PADDR_BITS'(B - 1);
  localparam logic [PADDR_BITS-1:0] BEAT_STEP = PADDR_BITS'(W / 8);

  typedef enum logic {F_COLLECT, F_PRESENT} fstate_t;
  typedef enum logic {W_IDLE, W_SEND}       wstate_t;

  // ---------------------------------------------------------------- fill path
  fstate_t                     r_fstate, w_fstate_nxt;
  logic [CW-1:0]               r_fcnt;
  logic [BEATS-1:0][W-1:0]     r_fline;
  logic [PADDR_BITS-1:0]       r_faddr;
  logic                        r_perr;
  logic                        w_fbeat, w_flast, w_fmis;

  // a flush in collect wins over a beat offered in the same cycle
  assign w_fbeat = llc_valid_in && (r_fstate == F_COLLECT) && !flush_in;
  assign w_flast = w_fbeat && (r_fcnt == LAST_BEAT);
  // beats after the first must stay inside the line captured on beat 0
  assign w_fmis  = w_fbeat && (r_fcnt != '0) &&
                   ((llc_addr_in & LINE_MASK) != r_faddr);

  // fill state register
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) r_fstate <= F_COLLECT;
    else           r_fstate <= w_fstate_nxt;
  end

  // fill next state: present after the last beat, collect again once taken
  always_comb begin
    w_fstate_nxt = r_fstate;
    unique case (r_fstate)
      F_COLLECT: if (w_flast)      w_fstate_nxt = F_PRESENT;
      F_PRESENT: if (l1d_ready_in) w_fstate_nxt = F_COLLECT;
      default:                     w_fstate_nxt = F_COLLECT;
    endcase
  end

  // fill datapath: beat counter, line buffer, line address, sticky error
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      r_fcnt  <= '0;
      r_fline <= '0;
      r_faddr <= '0;
      r_perr  <= 1'b0;
    end else begin
      if ((r_fstate == F_COLLECT) && flush_in) begin
        r_fcnt <= '0;
      end else if (w_fbeat) begin
        r_fline[r_fcnt] <= llc_value_in;
        if (r_fcnt == '0) r_faddr <= llc_addr_in & LINE_MASK;
        r_fcnt <= w_flast ? '0 : r_fcnt + 1'b1;
      end
      if (w_fmis) r_perr <= 1'b1;
    end
  end

  assign llc_ready_out    = (r_fstate == F_COLLECT);
  assign l1d_valid_out    = (r_fstate == F_PRESENT);
  assign l1d_addr_out     = r_faddr;
  assign l1d_line_out     = r_fline;
  assign protocol_err_out = r_perr;

  // ----------------------------------------------------------- writeback path
  wstate_t                     r_wstate, w_wstate_nxt;
  logic [CW-1:0]               r_widx;
  logic [BEATS-1:0][W-1:0]     r_wline;
  logic [PADDR_BITS-1:0]       r_waddr;
  logic                        w_wacc, w_wadv, w_wlast;

  assign w_wacc  = l1d_wb_valid_in && (r_wstate == W_IDLE);
  assign w_wadv  = (r_wstate == W_SEND) && llc_wb_ready_in;
  assign w_wlast = w_wadv && (r_widx == LAST_BEAT);

  // writeback state register
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) r_wstate <= W_IDLE;
    else           r_wstate <= w_wstate_nxt;
  end

  // writeback next state: send once a line is taken, idle after the last beat
  always_comb begin
    w_wstate_nxt = r_wstate;
    unique case (r_wstate)
      W_IDLE:  if (w_wacc)  w_wstate_nxt = W_SEND;
      W_SEND:  if (w_wlast) w_wstate_nxt = W_IDLE;
      default:              w_wstate_nxt = W_IDLE;
    endcase
  end

  // writeback datapath: captured line, aligned address, beat index
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      r_widx  <= '0;
      r_wline <= '0;
      r_waddr <= '0;
    end else if (w_wacc) begin
      r_wline <= l1d_wb_line_in;
      r_waddr <= l1d_wb_addr_in & LINE_MASK;
      r_widx  <= '0;
    end else if (w_wadv) begin
      r_widx  <= w_wlast ? '0 : r_widx + 1'b1;
    end
  end

  assign l1d_wb_ready_out = (r_wstate == W_IDLE);
  assign llc_wb_valid_out = (r_wstate == W_SEND);
  assign llc_wb_value_out = r_wline[r_widx];
  assign llc_wb_addr_out  = r_waddr + PADDR_BITS'(r_widx) * BEAT_STEP;

endmodule

// File: tb/tb_llc_l1d_line_bridge.sv
// Bench for llc_l1d_line_bridge: directed scenarios plus randomized concurrent
// fills and writebacks, checked against line-level expectations.
module tb_llc_l1d_line_bridge;

  localparam int PA    = 19;
  localparam int B     = 64;
  localparam int W     = 64;
  localparam int BEATS = 8 * B / W;
  localparam int LW    = 8 * B;

  logic          clk_in, rst_N_in, flush_in;
  logic          llc_valid_in, llc_ready_out;
  logic [PA-1:0] llc_addr_in;
  logic [W-1:0]  llc_value_in;
  logic          l1d_valid_out, l1d_ready_in;
  logic [PA-1:0] l1d_addr_out;
  logic [LW-1:0] l1d_line_out;
  logic          l1d_wb_valid_in, l1d_wb_ready_out;
  logic [PA-1:0] l1d_wb_addr_in;
  logic [LW-1:0] l1d_wb_line_in;
  logic          llc_wb_valid_out, llc_wb_ready_in;
  logic [PA-1:0] llc_wb_addr_out;
  logic [W-1:0]  llc_wb_value_out;
  logic          protocol_err_out;

  int checks = 0;
  int errors = 0;

  llc_l1d_line_bridge #(.PADDR_BITS(PA), .B(B), .W(W)) dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in), .flush_in(flush_in),
    .llc_valid_in(llc_valid_in), .llc_ready_out(llc_ready_out),
    .llc_addr_in(llc_addr_in), .llc_value_in(llc_value_in),
    .l1d_valid_out(l1d_valid_out), .l1d_ready_in(l1d_ready_in),
    .l1d_addr_out(l1d_addr_out), .l1d_line_out(l1d_line_out),
    .l1d_wb_valid_in(l1d_wb_valid_in), .l1d_wb_ready_out(l1d_wb_ready_out),
    .l1d_wb_addr_in(l1d_wb_addr_in), .l1d_wb_line_in(l1d_wb_line_in),
    .llc_wb_valid_out(llc_wb_valid_out), .llc_wb_ready_in(llc_wb_ready_in),
    .llc_wb_addr_out(llc_wb_addr_out), .llc_wb_value_out(llc_wb_value_out),
    .protocol_err_out(protocol_err_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // writeback beats seen on the LLC side; inputs change 1 after posedge, so
  // the negedge view is what the next posedge will see
  logic [PA-1:0] wb_aq[$];
  logic [W-1:0]  wb_dq[$];
  always @(negedge clk_in)
    if (rst_N_in && llc_wb_valid_out && llc_wb_ready_in) begin
      wb_aq.push_back(llc_wb_addr_out);
      wb_dq.push_back(llc_wb_value_out);
    end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int j = 0; j < LW / 32; j++) l[j*32 +: 32] = $urandom;
    return l;
  endfunction

  // hold the presented line for dly cycles, then take it
  task automatic consume_line(input int dly, input logic [LW-1:0] line);
    for (int i = 0; i < dly; i++) begin
      chk("hold_vld", LW'(l1d_valid_out), LW'(1));
      chk("hold_rdy", LW'(llc_ready_out), LW'(0));
      chk("hold_line", l1d_line_out, line);
      tick();
    end
    l1d_ready_in = 1'b1;
    tick();
    l1d_ready_in = 1'b0;
    chk("taken_vld", LW'(l1d_valid_out), LW'(0));
    chk("taken_rdy", LW'(llc_ready_out), LW'(1));
  endtask

  // send one whole line as BEATS fill beats; beat 0 may carry an unaligned address
  task automatic fill_line(input logic [PA-1:0] base, input logic [LW-1:0] line,
                           input int maxgap, input int maxdly, input bit consume);
    logic [PA-1:0] lb;
    lb = base & ~PA'(B - 1);
    for (int k = 0; k < BEATS; k++) begin
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      llc_valid_in = 1'b0;
      repeat (gap) tick();
      llc_valid_in = 1'b1;
      llc_addr_in  = (k == 0) ? base : lb + PA'(k * (W / 8));
      llc_value_in = line[k*W +: W];
      chk("fill_rdy", LW'(llc_ready_out), LW'(1));
      chk("fill_early", LW'(l1d_valid_out), LW'(0));
      tick();
    end
    llc_valid_in = 1'b0;
    chk("line_vld", LW'(l1d_valid_out), LW'(1));
    chk("line_addr", LW'(l1d_addr_out), LW'(lb));
    chk("line_data", l1d_line_out, line);
    if (consume) consume_line(maxdly, line);
  endtask

  // hand one line to the writeback path and check the beats it emits
  // mode 0: random LLC ready, 1: toggling, else always ready
  task automatic wb_line(input logic [PA-1:0] addr, input logic [LW-1:0] line, input int mode);
    logic [PA-1:0] lb;
    int n;
    lb = addr & ~PA'(B - 1);
    l1d_wb_valid_in = 1'b1;
    l1d_wb_addr_in  = addr;
    l1d_wb_line_in  = line;
    n = 0;
    while (!l1d_wb_ready_out && n < 50) begin tick(); n++; end
    chk("wb_take_rdy", LW'(l1d_wb_ready_out), LW'(1));
    tick();
    l1d_wb_valid_in = 1'b0;
    llc_wb_ready_in = 1'b0;
    n = 0;
    while (!l1d_wb_ready_out && n < 200) begin
      chk("wb_vld", LW'(llc_wb_valid_out), LW'(1));
      case (mode)
        0:       llc_wb_ready_in = 1'($urandom_range(1, 0));
        1:       llc_wb_ready_in = ~llc_wb_ready_in;
        default: llc_wb_ready_in = 1'b1;
      endcase
      tick();
      n++;
    end
    llc_wb_ready_in = 1'b0;
    chk("wb_done", LW'(l1d_wb_ready_out), LW'(1));
    chk("wb_count", LW'(wb_aq.size()), LW'(BEATS));
    for (int i = 0; i < wb_aq.size() && i < BEATS; i++) begin
      chk("wb_addr", LW'(wb_aq[i]), LW'(lb + PA'(i * (W / 8))));
      chk("wb_data", LW'(wb_dq[i]), LW'(line[i*W +: W]));
    end
    wb_aq.delete();
    wb_dq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LW-1:0] line, line2;

    rst_N_in = 1'b0; flush_in = 1'b0;
    llc_valid_in = 1'b0; llc_addr_in = '0; llc_value_in = '0;
    l1d_ready_in = 1'b0;
    l1d_wb_valid_in = 1'b0; l1d_wb_addr_in = '0; l1d_wb_line_in = '0;
    llc_wb_ready_in = 1'b0;

    // reset values, before any clock edge
    #2;
    chk("rst_llc_rdy", LW'(llc_ready_out), LW'(1));
    chk("rst_l1d_vld", LW'(l1d_valid_out), LW'(0));
    chk("rst_wb_rdy", LW'(l1d_wb_ready_out), LW'(1));
    chk("rst_wb_vld", LW'(llc_wb_valid_out), LW'(0));
    chk("rst_perr", LW'(protocol_err_out), LW'(0));
    chk("rst_l1d_addr", LW'(l1d_addr_out), LW'(0));
    chk("rst_l1d_line", l1d_line_out, LW'(0));
    chk("rst_wb_addr", LW'(llc_wb_addr_out), LW'(0));
    chk("rst_wb_data", LW'(llc_wb_value_out), LW'(0));
    tick(); tick();
    rst_N_in = 1'b1;
    tick();

    // back-to-back fill at 0x1040 with word k = k
    for (int k = 0; k < BEATS; k++) line[k*W +: W] = W'(k);
    fill_line(PA'(20'h1040), line, 0, 0, 1'b0);

    // line held unconsumed for 5 cycles while a beat is offered; flush ignored
    llc_valid_in = 1'b1;
    llc_addr_in  = PA'(20'h1040);
    llc_value_in = W'(64'hBAD0BAD0BAD0BAD0);
    for (int i = 0; i < 5; i++) begin
      flush_in = (i == 2);
      chk("stall_rdy", LW'(llc_ready_out), LW'(0));
      chk("stall_vld", LW'(l1d_valid_out), LW'(1));
      chk("stall_addr", LW'(l1d_addr_out), LW'(20'h1040));
      chk("stall_line", l1d_line_out, line);
      tick();
    end
    flush_in = 1'b0;
    llc_valid_in = 1'b0;
    consume_line(0, line);
    chk("no_junk_line", l1d_line_out, line);

    // writeback at 0x2000 with LLC ready toggling
    wb_line(PA'(20'h2000), rand_line(), 1);

    // flush after 3 beats, then a fresh line must contain only new beats
    llc_valid_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      llc_addr_in  = PA'(20'h5000 + k * 8);
      llc_value_in = W'(64'hAAAA0000 + k);
      tick();
    end
    flush_in = 1'b1;
    llc_value_in = W'(64'hDEAD);
    tick();
    flush_in = 1'b0;
    llc_valid_in = 1'b0;
    chk("flush_no_line", LW'(l1d_valid_out), LW'(0));
    line2 = rand_line();
    fill_line(PA'(20'h6000), line2, 0, 1, 1'b1);

    // randomized concurrent fills and writebacks
    for (int it = 0; it < 12; it++) begin
      logic [LW-1:0] fl, wl;
      logic [PA-1:0] fa, wa;
      int wm;
      fl = rand_line(); wl = rand_line();
      fa = PA'($urandom); wa = PA'($urandom);
      wm = it % 3;
      fork
        fill_line(fa, fl, 2, 3, 1'b1);
        wb_line(wa, wl, wm);
      join
    end
    chk("perr_clean", LW'(protocol_err_out), LW'(0));

    // beat 1 outside the line of beat 0: stored, error sticks
    llc_valid_in = 1'b1;
    llc_addr_in = PA'(20'h1040); llc_value_in = W'(64'h10);
    tick();
    llc_addr_in = PA'(20'h1080); llc_value_in = W'(64'h11);
    tick();
    chk("perr_set", LW'(protocol_err_out), LW'(1));
    for (int k = 2; k < BEATS; k++) begin
      llc_addr_in  = PA'(20'h1040 + k * 8);
      llc_value_in = W'(64'h10 + k);
      tick();
    end
    llc_valid_in = 1'b0;
    chk("perr_line_vld", LW'(l1d_valid_out), LW'(1));
    chk("perr_line_addr", LW'(l1d_addr_out), LW'(20'h1040));
    chk("perr_beat1", LW'(l1d_line_out[W +: W]), LW'(64'h11));
    consume_line(0, l1d_line_out);
    repeat (3) tick();
    chk("perr_sticky", LW'(protocol_err_out), LW'(1));

    // reset in the middle of a fill and during writeback beat 4
    llc_valid_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      llc_addr_in  = PA'(20'h3000 + k * 8);
      llc_value_in = W'(64'h100 + k);
      tick();
    end
    llc_valid_in = 1'b0;
    l1d_wb_valid_in = 1'b1;
    l1d_wb_addr_in  = PA'(20'h2000);
    l1d_wb_line_in  = rand_line();
    tick();
    l1d_wb_valid_in = 1'b0;
    llc_wb_ready_in = 1'b1;
    repeat (4) tick();
    chk("b4_vld", LW'(llc_wb_valid_out), LW'(1));
    chk("b4_addr", LW'(llc_wb_addr_out), LW'(20'h2020));
    rst_N_in = 1'b0;
    #1;
    chk("arst_wb_vld", LW'(llc_wb_valid_out), LW'(0));
    chk("arst_perr", LW'(protocol_err_out), LW'(0));
    chk("arst_llc_rdy", LW'(llc_ready_out), LW'(1));
    llc_wb_ready_in = 1'b0;
    tick(); tick();
    rst_N_in = 1'b1;
    tick();
    chk("post_wb_rdy", LW'(l1d_wb_ready_out), LW'(1));
    chk("post_wb_vld", LW'(llc_wb_valid_out), LW'(0));
    chk("post_wb_beats", LW'(wb_aq.size()), LW'(4));
    wb_aq.delete();
    wb_dq.delete();
    repeat (3) tick();
    chk("post_no_line", LW'(l1d_valid_out), LW'(0));
    chk("post_no_beat", LW'(wb_aq.size()), LW'(0));
    fill_line(PA'($urandom), rand_line(), 1, 2, 1'b1);
    wb_line(PA'($urandom), rand_line(), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/llc_l1d_line_bridge.md
LLC_L1D_LINE_BRIDGE -- requirements
Module: llc_l1d_line_bridge

Interface
REQ-001 Parameter PADDR_BITS, default 19: physical address width.
REQ-002 Parameter B, default 64: cache line size in bytes.
REQ-003 Parameter W, default 64: LLC beat width in bits; BEATS = 8*B/W (8 at defaults); 8*B SHALL be a multiple of W.
REQ-004 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_N_in  input  1  reset, asynchronous assert and active-low.
REQ-006 flush_in  input  1  synchronous discard of a partially collected fill.
REQ-007 llc_valid_in / llc_ready_out  input / output  1 / 1  fill beat handshake from the LLC.
REQ-008 llc_addr_in / llc_value_in  input / input  PADDR_BITS / W  fill beat byte address and data.
REQ-009 l1d_valid_out / l1d_ready_in  output / input  1 / 1  assembled-line handshake to the L1D.
REQ-010 l1d_addr_out / l1d_line_out  output / output  PADDR_BITS / 8*B  line-aligned address and full line.
REQ-011 l1d_wb_valid_in / l1d_wb_ready_out  input / output  1 / 1  writeback line handshake from the L1D.
REQ-012 l1d_wb_addr_in / l1d_wb_line_in  input / input  PADDR_BITS / 8*B  writeback address and line.
REQ-013 llc_wb_valid_out / llc_wb_ready_in  output / input  1 / 1  writeback beat handshake to the LLC.
REQ-014 llc_wb_addr_out / llc_wb_value_out  output / output  PADDR_BITS / W  writeback beat address and data.
REQ-015 protocol_err_out  output  1  sticky flag for a fill beat outside the current line.

Function
REQ-016 A transfer occurs only on a cycle where valid and ready are both high; valid, address and data SHALL remain stable while valid is high and ready is low.
REQ-017 The fill path and the writeback path SHALL be independent and operate concurrently.
REQ-018 Fill FSM states: F_COLLECT and F_PRESENT; reset state F_COLLECT with beat count 0.
REQ-019 In F_COLLECT, llc_ready_out SHALL be 1; in F_PRESENT it SHALL be 0.
REQ-020 Accepted fill beat k (0..BEATS-1) SHALL be written into line bits [W*k +: W].
REQ-021 On beat 0, the line address SHALL be captured as llc_addr_in with the low log2(B) bits zeroed.
REQ-022 On beats 1..BEATS-1, if llc_addr_in differs from the captured line address above bit log2(B)-1, the beat SHALL still be stored and protocol_err_out SHALL set to 1 and stay 1 until reset.
REQ-023 On acceptance of beat BEATS-1, the FSM SHALL enter F_PRESENT; l1d_valid_out SHALL be 1 on the next cycle (1-cycle latency from the last beat).
REQ-024 In F_PRESENT, l1d_valid_out, l1d_addr_out and l1d_line_out SHALL hold until l1d_ready_in=1; on that edge the FSM SHALL return to F_COLLECT with count 0.
REQ-025 flush_in=1 in F_COLLECT SHALL clear the beat count and drop any beat offered that cycle; in F_PRESENT it SHALL have no effect.
REQ-026 Writeback FSM states: W_IDLE and W_SEND; reset state W_IDLE.
REQ-027 l1d_wb_ready_out SHALL be 1 only in W_IDLE; an accepted line SHALL be captured with its address (low log2(B) bits zeroed) and move the FSM to W_SEND with beat index 0.
REQ-028 In W_SEND, llc_wb_valid_out=1, llc_wb_value_out=line[W*i +: W], and llc_wb_addr_out=line address + i*(W/8).
REQ-029 The beat index SHALL advance only on llc_wb_ready_in=1; after beat BEATS-1 is accepted the FSM SHALL return to W_IDLE, and l1d_wb_ready_out SHALL be 1 on the following cycle.
REQ-030 flush_in SHALL NOT affect the writeback path.

Reset
REQ-031 While rst_N_in=0, both FSMs, counters and protocol_err_out SHALL clear immediately, regardless of the clock.
REQ-032 Reset output values: llc_ready_out=1, l1d_valid_out=0, l1d_wb_ready_out=1, llc_wb_valid_out=0, protocol_err_out=0, and all address and data outputs 0.
REQ-033 A reset asserted mid-fill or mid-writeback SHALL discard the partial transfer without emitting any further beat or line.

Verification
REQ-034 Eight back-to-back fill beats at address 0x1040 with data 0..7 -> l1d_valid_out=1 one cycle after the last beat, l1d_addr_out=0x1040, l1d_line_out word k = k.
REQ-035 Full line presented while l1d_ready_in is held at 0 for 5 cycles -> the line is held stable, llc_ready_out=0 throughout, and no beat is accepted.
REQ-036 Writeback at 0x2000 with llc_wb_ready_in toggling every cycle -> beats are emitted at addresses 0x2000, 0x2008, ..., 0x2038 in order with the matching line words, and none is duplicated or lost.
REQ-037 flush_in pulsed after 3 fill beats, then 8 new beats sent -> the presented line contains only the new beats.
REQ-038 Fill beat 0 at 0x1040 followed by beat 1 at 0x1080 -> protocol_err_out=1 and stays 1 until reset.
REQ-039 rst_N_in asserted during writeback beat 4 -> llc_wb_valid_out=0 immediately, and l1d_wb_ready_out=1 after reset is released.
